// File: rtl/fp_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_iter
// Brief    : Iterative IEEE-754 divider, one quotient bit per cycle, RNE.
// Revision : 1.0
// ============================================================================
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   zero_division,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);

    localparam int c_w     = 1 + EXP_W + MAN_W;
    localparam int c_cnt_w = $clog2(MAN_W + 3);
    localparam logic [c_cnt_w-1:0]       c_last    = c_cnt_w'(MAN_W + 2);
    localparam logic [EXP_W+1:0]         c_bias    = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W+1:0]  c_exp_max = (EXP_W+2)'(2**EXP_W - 1);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_spec = 3'd1;
    localparam logic [2:0] c_div  = 3'd2;
    localparam logic [2:0] c_rnd  = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

    logic [2:0]               r_state;
    logic                     r_first;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [c_w-1:0]           r_a;
    logic [c_w-1:0]           r_b;
    logic [c_w-1:0]           r_result;
    logic [3:0]               r_flags;       // {invalid, zero_division, overflow, underflow}
    logic [MAN_W:0]           r_mb;
    logic [MAN_W+1:0]         r_rem;
    logic [MAN_W+2:0]         r_q;
    logic signed [EXP_W+1:0]  r_exp;
    logic [c_cnt_w-1:0]       r_cnt;

    logic [EXP_W-1:0]         w_ea, w_eb;
    logic [MAN_W-1:0]         w_fa, w_fb;
    logic [MAN_W:0]           w_ma, w_mb;
    logic                     w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                     w_sign, w_pre, w_in_special;
    logic [c_w-1:0]           w_spec_res;
    logic [3:0]               w_spec_flags;

    assign w_ea     = r_a[c_w-2:MAN_W];
    assign w_eb     = r_b[c_w-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_ma     = {1'b1, w_fa};
    assign w_mb     = {1'b1, w_fb};
    assign w_pre    = (w_ma < w_mb);
    assign w_sign   = r_a[c_w-1] ^ r_b[c_w-1];
    // Subnormal operands (exp==0) count as zero.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (|w_fa);
    assign w_b_nan  = (&w_eb) && (|w_fb);

    assign w_in_special = (a[c_w-2:MAN_W] == '0) || (&a[c_w-2:MAN_W]) ||
                          (b[c_w-2:MAN_W] == '0) || (&b[c_w-2:MAN_W]);

    always_comb begin
        w_spec_res   = {w_sign, {(c_w-1){1'b0}}};
        w_spec_flags = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_spec_flags = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_spec_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_flags = 4'b0100;
        end
    end

    // Rounding: quotient holds 1.f[MAN_W] G R, sticky comes from the remainder.
    logic [MAN_W:0]           w_mant;
    logic                     w_up, w_carry;
    logic [MAN_W+1:0]         w_mant_r;
    logic [MAN_W-1:0]         w_frac_r;
    logic signed [EXP_W+1:0]  w_exp_r;
    logic [c_w-1:0]           w_nrm_res;
    logic [3:0]               w_nrm_flags;
    logic                     w_rem_ge;
    logic [MAN_W+1:0]         w_rem_sel;

    assign w_mant    = r_q[MAN_W+2:2];
    assign w_up      = r_q[1] && (r_q[0] || (|r_rem) || w_mant[0]);
    assign w_mant_r  = {1'b0, w_mant} + (MAN_W+2)'(w_up);
    assign w_carry   = w_mant_r[MAN_W+1];
    assign w_frac_r  = w_carry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    assign w_exp_r   = r_exp + (EXP_W+2)'(w_carry);
    assign w_rem_ge  = (r_rem >= {1'b0, r_mb});
    assign w_rem_sel = w_rem_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

    always_comb begin
        w_nrm_res   = {w_sign, w_exp_r[EXP_W-1:0], w_frac_r};
        w_nrm_flags = 4'b0000;
        if (w_exp_r >= c_exp_max) begin
            w_nrm_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_nrm_flags = 4'b0010;
        end else if (w_exp_r[EXP_W+1] || (w_exp_r == '0)) begin
            w_nrm_res   = {w_sign, {(c_w-1){1'b0}}};
            w_nrm_flags = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_first     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_mb        <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_first    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= w_in_special ? c_spec : c_div;
                    end
                end
                c_spec: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else begin
                        r_result    <= w_spec_res;
                        r_flags     <= w_spec_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= c_done;
                    end
                end
                c_div: begin
                    if (r_first) begin
                        // Pre-shift when ma<mb so the leading quotient bit is always 1.
                        r_first <= 1'b0;
                        r_mb    <= w_mb;
                        r_rem   <= w_pre ? {w_ma, 1'b0} : {1'b0, w_ma};
                        r_exp   <= {2'b00, w_ea} - {2'b00, w_eb} + c_bias - (EXP_W+2)'(w_pre);
                        r_q     <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_rem <= {w_rem_sel[MAN_W:0], 1'b0};
                        r_q   <= {r_q[MAN_W+1:0], w_rem_ge};
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last) begin
                            r_state <= c_rnd;
                        end
                    end
                end
                c_rnd: begin
                    r_result    <= w_nrm_res;
                    r_flags     <= w_nrm_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= c_done;
                end
                c_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign invalid       = r_flags[3];
    assign zero_division = r_flags[2];
    assign overflow      = r_flags[1];
    assign underflow     = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_fp_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_iter
// Brief    : Self-checking bench for fp_div_iter (single and half precision).
// Revision : 1.0
// ============================================================================
module tb_fp_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        zero_division, overflow, underflow, invalid;
    logic [3:0]  w_flags;
    assign w_flags = {invalid, zero_division, overflow, underflow};

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic        h_zdiv, h_ovf, h_unf, h_inv;

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero_division(zero_division), .overflow(overflow), .underflow(underflow),
        .invalid(invalid)
    );

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
        .zero_division(h_zdiv), .overflow(h_ovf), .underflow(h_unf), .invalid(h_inv)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Flags {invalid, zero_division, overflow, underflow}; rounding via double precision.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] dx, dy, dq;
        logic [23:0] m;
        logic        up;
        int          fe;
        dx = {x[31], 11'({3'b000, x[30:23]}) + 11'd896, x[22:0], 29'd0};
        dy = {y[31], 11'({3'b000, y[30:23]}) + 11'd896, y[22:0], 29'd0};
        dq = $realtobits($bitstoreal(dx) / $bitstoreal(dy));
        up = dq[28] && ((|dq[27:0]) || dq[29]);
        m  = {1'b0, dq[51:29]} + 24'(up);
        fe = int'(dq[62:52]) - 1023 + 127 + int'(m[23]);
        e.lat = 28;
        if (fe >= 255) begin
            e.res = {dq[63], 8'hFF, 23'd0};
            e.flags = 4'b0010;
        end else if (fe <= 0) begin
            e.res = {dq[63], 31'd0};
            e.flags = 4'b0001;
        end else begin
            e.res = {dq[63], 8'(fe), m[22:0]};
            e.flags = 4'b0000;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input exp_t e);
        sb_q.push_back(e);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout actual=0 expected=1");
        end
    endtask

    task automatic check_pop(input int n);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk("result", result, e.res);
            chk("flags", {28'd0, w_flags}, {28'd0, e.flags});
            chk("latency", 32'(n), 32'(e.lat));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_clear", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic collect();
        int n;
        wait_valid(n);
        if (out_valid) begin
            check_pop(n);
            handshake();
        end else begin
            void'(sb_q.pop_front());
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic run_half(input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] exp_res, input logic [3:0] exp_flags,
                            input int exp_lat);
        int n;
        h_a = va;
        h_b = vb;
        h_in_valid = 1'b1;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        n = 0;
        while (!h_out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("h_result", {16'd0, h_result}, {16'd0, exp_res});
        chk("h_flags", {28'd0, h_inv, h_zdiv, h_ovf, h_unf}, {28'd0, exp_flags});
        chk("h_latency", 32'(n), 32'(exp_lat));
        h_out_ready = 1'b1;
        @(posedge clk);
        #1;
        h_out_ready = 1'b0;
    endtask

    initial begin
        exp_t        e;
        int          n;
        logic [31:0] x, y;

        vecs[0]  = '{32'hC0CCCCCC, 32'hBF000000, 32'h414CCCCC, 4'b0000, 28};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28};
        vecs[2]  = '{32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 28};
        vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2};
        vecs[5]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28};
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28};
        vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 2};
        vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2};
        vecs[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 2};
        vecs[11] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 2};
        vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 2};
        vecs[13] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 4'b0100, 2};
        vecs[14] = '{32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 28};
        vecs[15] = '{32'h3F800001, 32'h3F800000, 32'h3F800001, 4'b0000, 28};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        h_in_valid = 1'b0;
        h_out_ready = 1'b0;
        h_a = '0;
        h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, w_flags}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            e.res = vecs[i].res;
            e.flags = vecs[i].flags;
            e.lat = vecs[i].lat;
            issue(vecs[i].a, vecs[i].b, e);
            collect();
        end

        for (int i = 0; i < 1500; i++) begin
            x = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            y = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            issue(x, y, model(x, y));
            collect();
        end

        // Stall the consumer: output must hold, new requests must be ignored.
        e.res = 32'h3FC00000;
        e.flags = 4'b0000;
        e.lat = 28;
        issue(32'h40400000, 32'h40000000, e);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_result", result, 32'h3FC00000);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        check_pop(n);
        handshake();
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (35) @(posedge clk);
        #1;
        chk("no_ghost_op", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of an iteration.
        e.res = 32'h3EAAAAAB;
        issue(32'h3F800000, 32'h40400000, e);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_result", result, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'h3F800000, 32'h40400000, e);
        collect();

        run_half(16'h3C00, 16'h4000, 16'h3800, 4'b0000, 15);
        run_half(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 15);
        run_half(16'h7C00, 16'h7C00, 16'h7E00, 4'b1000, 2);
        run_half(16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
